// File: rtl/rename_reg_file_pkg.sv
// Shared widths and zero constants for the rename register file.
package rename_reg_file_pkg;
   localparam int DATA_W       = 32;
   localparam int NUM_REGS     = 32;
   localparam int TAG_W        = 4;
   localparam int NUM_RD_PORTS = 2;
   localparam int IDX_W        = $clog2(NUM_REGS);

   localparam logic [TAG_W-1:0]  ZERO_TAG  = '0;
   localparam logic [IDX_W-1:0]  ZERO_IDX  = '0;
   localparam logic [DATA_W-1:0] ZERO_WORD = '0;

   typedef logic [NUM_REGS-1:0][DATA_W-1:0] v_arr_t;
   typedef logic [NUM_REGS-1:0][TAG_W-1:0]  q_arr_t;
endpackage

// File: rtl/rename_reg_file_read_port.sv
// One combinational source-operand port: lookup, x0 force and, with RF_COMMIT_BYPASS_EN,
// a same-cycle forward of a matching commit.
module rf_read_port
   import rename_reg_file_pkg::*;
(
   input  logic              rst,
   input  logic [IDX_W-1:0]  rs,
   input  v_arr_t            v_arr,
   input  q_arr_t            q_arr,
   input  logic              commit_en,
   input  logic [IDX_W-1:0]  commit_rd,
   input  logic [TAG_W-1:0]  commit_tag,
   input  logic [DATA_W-1:0] commit_val,
   output logic [DATA_W-1:0] v,
   output logic [TAG_W-1:0]  q
);
`ifndef RF_COMMIT_BYPASS_EN
   logic unused_bypass;
   assign unused_bypass = ^{rst, commit_en, commit_rd, commit_tag, commit_val};
`endif

   always_comb begin
      v = v_arr[rs];
      q = q_arr[rs];
`ifdef RF_COMMIT_BYPASS_EN
      // Forward only when the commit releases this register's current producer.
      if (!rst && commit_en && (rs == commit_rd) && (q_arr[rs] == commit_tag)) begin
         v = commit_val;
         q = ZERO_TAG;
      end
`endif
      if (rs == ZERO_IDX) begin
         v = ZERO_WORD;
         q = ZERO_TAG;
      end
   end
endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with rename tags; optional commit bypass via RF_COMMIT_BYPASS_EN.
module rename_reg_file
   import rename_reg_file_pkg::*;
(
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_RD_PORTS*IDX_W-1:0]  rs_i,
   output logic [NUM_RD_PORTS*DATA_W-1:0] v_o,
   output logic [NUM_RD_PORTS*TAG_W-1:0]  q_o,
   input  logic                           alloc_en_i,
   input  logic [IDX_W-1:0]               alloc_rd_i,
   input  logic [TAG_W-1:0]               alloc_tag_i,
   input  logic                           commit_en_i,
   input  logic [IDX_W-1:0]               commit_rd_i,
   input  logic [TAG_W-1:0]               commit_tag_i,
   input  logic [DATA_W-1:0]              commit_val_i,
   input  logic                           flush_i
);
   v_arr_t v_mem;
   q_arr_t q_mem;

   // Later assignments to q_mem win, so alloc overrides the commit release.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_mem <= '0;
         q_mem <= '0;
      end else begin
         if (commit_en_i && (commit_rd_i != ZERO_IDX))
            v_mem[commit_rd_i] <= commit_val_i;
         if (flush_i) begin
            q_mem <= '0;
         end else begin
            if (commit_en_i && (commit_rd_i != ZERO_IDX) && (q_mem[commit_rd_i] == commit_tag_i))
               q_mem[commit_rd_i] <= ZERO_TAG;
            if (alloc_en_i && (alloc_rd_i != ZERO_IDX))
               q_mem[alloc_rd_i] <= alloc_tag_i;
         end
      end
   end

   for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
      rf_read_port u_port (
         .rst        (rst),
         .rs         (rs_i[k*IDX_W +: IDX_W]),
         .v_arr      (v_mem),
         .q_arr      (q_mem),
         .commit_en  (commit_en_i),
         .commit_rd  (commit_rd_i),
         .commit_tag (commit_tag_i),
         .commit_val (commit_val_i),
         .v          (v_o[k*DATA_W +: DATA_W]),
         .q          (q_o[k*TAG_W +: TAG_W])
      );
   end
endmodule

// File: tb/tb_rename_reg_file.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against an array-based reference model.
module tb_rename_reg_file;
   localparam int DW = 32;
   localparam int NR = 32;
   localparam int TW = 4;
   localparam int NP = 2;
   localparam int IW = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic [NP*IW-1:0] rs_i;
   logic [NP*DW-1:0] v_o;
   logic [NP*TW-1:0] q_o;
   logic            alloc_en_i;
   logic [IW-1:0]   alloc_rd_i;
   logic [TW-1:0]   alloc_tag_i;
   logic            commit_en_i;
   logic [IW-1:0]   commit_rd_i;
   logic [TW-1:0]   commit_tag_i;
   logic [DW-1:0]   commit_val_i;
   logic            flush_i;

   int checks = 0;
   int errors = 0;
   bit done = 0;

   logic [DW-1:0] m_v [NR];
   logic [TW-1:0] m_q [NR];

   rename_reg_file dut (
      .clk(clk), .rst(rst), .rs_i(rs_i), .v_o(v_o), .q_o(q_o),
      .alloc_en_i(alloc_en_i), .alloc_rd_i(alloc_rd_i), .alloc_tag_i(alloc_tag_i),
      .commit_en_i(commit_en_i), .commit_rd_i(commit_rd_i), .commit_tag_i(commit_tag_i),
      .commit_val_i(commit_val_i), .flush_i(flush_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] port_v(input int k);
      return v_o[k*DW +: DW];
   endfunction
   function automatic logic [DW-1:0] port_q(input int k);
      return {{(DW-TW){1'b0}}, q_o[k*TW +: TW]};
   endfunction

   // Reference model: state advances on each rising edge from the sampled inputs.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NR; i++) begin m_v[i] = '0; m_q[i] = '0; end
      end else begin
         logic release_ok;
         release_ok = commit_en_i && commit_rd_i != 0 && m_q[commit_rd_i] == commit_tag_i;
         if (commit_en_i && commit_rd_i != 0) m_v[commit_rd_i] = commit_val_i;
         if (flush_i) begin
            for (int i = 0; i < NR; i++) m_q[i] = '0;
         end else begin
            if (release_ok) m_q[commit_rd_i] = '0;
            if (alloc_en_i && alloc_rd_i != 0) m_q[alloc_rd_i] = alloc_tag_i;
         end
      end
   end

   // Every-cycle compare of both read ports against the model.
   always @(negedge clk) begin
      if (!done && rst !== 1'bx) begin
         for (int k = 0; k < NP; k++) begin
            int r;
            logic [DW-1:0] ev;
            logic [TW-1:0] eq;
            r  = int'(rs_i[k*IW +: IW]);
            ev = (r == 0) ? '0 : m_v[r];
            eq = (r == 0) ? '0 : m_q[r];
`ifdef RF_COMMIT_BYPASS_EN
            if (!rst && commit_en_i && r != 0 && r == int'(commit_rd_i) && m_q[r] == commit_tag_i) begin
               ev = commit_val_i;
               eq = '0;
            end
`endif
            check($sformatf("model_v%0d", k), port_v(k), ev);
            check($sformatf("model_q%0d", k), port_q(k), {{(DW-TW){1'b0}}, eq});
         end
      end
   end

   task automatic idle();
      alloc_en_i = 0; alloc_rd_i = 0; alloc_tag_i = 0;
      commit_en_i = 0; commit_rd_i = 0; commit_tag_i = 0; commit_val_i = 0;
      flush_i = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
      idle();
   endtask

   task automatic set_rs(input int a, input int b);
      rs_i = {5'(b), 5'(a)};
   endtask

   task automatic alloc(input int rd, input int tag);
      alloc_en_i = 1; alloc_rd_i = IW'(rd); alloc_tag_i = TW'(tag);
   endtask

   task automatic commit(input int rd, input int tag, input logic [DW-1:0] val);
      commit_en_i = 1; commit_rd_i = IW'(rd); commit_tag_i = TW'(tag); commit_val_i = val;
   endtask

   initial begin
      rst = 1; idle(); set_rs(5, 31);
      next_cycle();
      rst = 0;
      @(negedge clk);
      check("rst_v0", port_v(0), 0); check("rst_q0", port_q(0), 0);
      check("rst_v1", port_v(1), 0); check("rst_q1", port_q(1), 0);

      next_cycle(); alloc(3, 5); set_rs(3, 3);
      next_cycle();
      @(negedge clk);
      check("alloc_q", port_q(0), 5); check("alloc_q_dup", port_q(1), 5);
      commit(3, 5, 32'hDEADBEEF);
      next_cycle();
      @(negedge clk);
      check("commit_v", port_v(0), 32'hDEADBEEF); check("commit_q", port_q(0), 0);

      alloc(4, 2); set_rs(4, 0);
      next_cycle(); alloc(4, 7);
      next_cycle(); commit(4, 2, 32'h11);
      next_cycle();
      @(negedge clk);
      check("stale_v", port_v(0), 32'h11); check("stale_q", port_q(0), 7);

      alloc(1, 3);
      next_cycle(); alloc(2, 6);
      next_cycle(); flush_i = 1; commit(1, 3, 32'h42); alloc(9, 4); set_rs(1, 2);
      next_cycle();
      @(negedge clk);
      check("flush_v1", port_v(0), 32'h42); check("flush_q1", port_q(0), 0);
      check("flush_q2", port_q(1), 0);
      set_rs(9, 0);
      #1 check("flush_q9", port_q(0), 0);

      alloc(0, 1); commit(0, 1, 32'hFF);
      next_cycle(); set_rs(0, 0);
      @(negedge clk);
      check("x0_v", port_v(0), 0); check("x0_q", port_q(1), 0);

      alloc(7, 9); set_rs(7, 7);
      next_cycle(); commit(7, 9, 32'h1234);
      @(negedge clk);
`ifdef RF_COMMIT_BYPASS_EN
      check("byp_v", port_v(0), 32'h1234); check("byp_q", port_q(0), 0);
`else
      check("nobyp_v", port_v(0), 0); check("nobyp_q", port_q(0), 9);
`endif
      next_cycle();
      @(negedge clk);
      check("post_commit_v", port_v(1), 32'h1234); check("post_commit_q", port_q(1), 0);

      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         idle();
         rst = ($urandom_range(0, 199) == 0);
         set_rs(int'($urandom_range(0, NR-1)), int'($urandom_range(0, NR-1)));
         if ($urandom_range(0, 1) == 1) alloc(int'($urandom_range(0, NR-1)), int'($urandom_range(1, 15)));
         if ($urandom_range(0, 2) != 0) begin
            int rd;
            rd = ($urandom_range(0, 3) == 0) ? int'(rs_i[IW-1:0]) : int'($urandom_range(0, NR-1));
            commit(rd, ($urandom_range(0, 2) != 0) ? int'(m_q[rd]) : int'($urandom_range(1, 15)),
                   $urandom());
            if (commit_tag_i == 0) commit_tag_i = 1;
         end
         flush_i = ($urandom_range(0, 39) == 0);
      end
      @(negedge clk);
      done = 1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
